// File: rtl/topk_candidate_feeder.sv
// Producer side of the Viterbi candidate interface: streams one frame of class scores,
// keeps a sorted top-3 and hands it to the decoder. Optional watchdog: TOPK_TIMEOUT_EN.
module topk_candidate_feeder #(
    parameter int NUM_CLASS = 27,
    parameter int PROB_W    = 32,
    parameter int CHAR_W    = 5
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_score_valid,
    input  logic [PROB_W-1:0]           i_score,
    input  logic                        i_score_last,
    input  logic                        i_word_begin,
    output logic                        o_score_ready,
    output logic [2:0][PROB_W-1:0]      o_prob,
    output logic [2:0][CHAR_W-1:0]      o_char,
    output logic                        o_start,
    output logic                        o_next,
    input  logic                        i_stepped,
    output logic                        o_busy,
    output logic                        o_timeout
);

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_ISSUE, S_WAIT} state_t;

    state_t                   state;
    logic [CHAR_W-1:0]        idx;
    logic                     word;
    logic [2:0][PROB_W-1:0]   top_prob;
    logic [2:0][CHAR_W-1:0]   top_char;

    logic [2:0][PROB_W-1:0]   base_prob, ins_prob;
    logic [2:0][CHAR_W-1:0]   base_char, ins_char;
    logic [CHAR_W-1:0]        cur_char;
    logic                     accept, frame_end, word_now;

`ifdef TOPK_TIMEOUT_EN
    logic [7:0] wd;
    logic       timeout_q;
    assign o_timeout = timeout_q;
`else
    assign o_timeout = 1'b0;
`endif

    assign o_score_ready = (state == S_IDLE) || (state == S_COLLECT);
    assign accept        = i_score_valid && o_score_ready;

    always_comb begin
        // In S_IDLE the frame starts from an empty list, whatever the regs hold.
        base_prob = (state == S_IDLE) ? '0 : top_prob;
        base_char = (state == S_IDLE) ? '0 : top_char;
        cur_char  = (state == S_IDLE) ? '0 : idx;
        word_now  = (state == S_IDLE) ? i_word_begin : word;
        frame_end = i_score_last ||
                    ((state == S_IDLE) ? (NUM_CLASS == 1) : (idx == CHAR_W'(NUM_CLASS - 1)));
        ins_prob  = base_prob;
        ins_char  = base_char;
        // Strictly-greater compare: ties leave the earlier index ranked higher.
        if (i_score > base_prob[0]) begin
            ins_prob[2] = base_prob[1];  ins_char[2] = base_char[1];
            ins_prob[1] = base_prob[0];  ins_char[1] = base_char[0];
            ins_prob[0] = i_score;       ins_char[0] = cur_char;
        end else if (i_score > base_prob[1]) begin
            ins_prob[2] = base_prob[1];  ins_char[2] = base_char[1];
            ins_prob[1] = i_score;       ins_char[1] = cur_char;
        end else if (i_score > base_prob[2]) begin
            ins_prob[2] = i_score;       ins_char[2] = cur_char;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= S_IDLE;
            idx      <= '0;
            word     <= 1'b0;
            top_prob <= '0;
            top_char <= '0;
            o_prob   <= '0;
            o_char   <= '0;
            o_start  <= 1'b0;
            o_next   <= 1'b0;
            o_busy   <= 1'b0;
`ifdef TOPK_TIMEOUT_EN
            wd        <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            o_start <= 1'b0;
            o_next  <= 1'b0;
`ifdef TOPK_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            case (state)
                S_IDLE, S_COLLECT: begin
                    if (accept) begin
                        top_prob <= ins_prob;
                        top_char <= ins_char;
                        if (state == S_IDLE) word <= i_word_begin;
                        if (frame_end) begin
                            // Outputs load with the final insertion so the pulse lands in S_ISSUE.
                            idx     <= '0;
                            state   <= S_ISSUE;
                            o_prob  <= ins_prob;
                            o_char  <= ins_char;
                            o_start <= word_now;
                            o_next  <= !word_now;
                            o_busy  <= 1'b1;
                        end else begin
                            idx   <= cur_char + CHAR_W'(1);
                            state <= S_COLLECT;
                        end
                    end else if (state == S_IDLE) begin
                        top_prob <= '0;
                        top_char <= '0;
                    end
                end
                S_ISSUE: begin
                    state <= S_WAIT;
`ifdef TOPK_TIMEOUT_EN
                    wd    <= '0;
`endif
                end
                S_WAIT: begin
                    if (i_stepped) begin
                        state  <= S_IDLE;
                        idx    <= '0;
                        o_busy <= 1'b0;
                    end
`ifdef TOPK_TIMEOUT_EN
                    else if (wd == 8'd254) begin
                        state     <= S_IDLE;
                        idx       <= '0;
                        o_busy    <= 1'b0;
                        timeout_q <= 1'b1;
                    end else begin
                        wd <= wd + 8'd1;
                    end
`endif
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_topk_candidate_feeder.sv
// Bench for topk_candidate_feeder: hand-derived frame vectors, random frames against a
// sort-based reference, wait-hold, mid-frame reset and watchdog sequences.
module tb_topk_candidate_feeder;

    localparam int NC = 27;
    localparam int PW = 32;
    localparam int CW = 5;

    logic                  clk, rst_n;
    logic                  score_valid, score_last, word_begin, stepped;
    logic [PW-1:0]         score;
    logic                  score_ready, start, nxt, busy, timeout;
    logic [2:0][PW-1:0]    prob;
    logic [2:0][CW-1:0]    chr;

    topk_candidate_feeder #(.NUM_CLASS(NC), .PROB_W(PW), .CHAR_W(CW)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_score_valid(score_valid), .i_score(score), .i_score_last(score_last),
        .i_word_begin(word_begin), .o_score_ready(score_ready),
        .o_prob(prob), .o_char(chr), .o_start(start), .o_next(nxt),
        .i_stepped(stepped), .o_busy(busy), .o_timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [NC-1:0][PW-1:0] sc;
        int                    n;
        bit                    wb;
        logic [2:0][PW-1:0]    ep;
        logic [2:0][CW-1:0]    ec;
    } vec_t;

    vec_t                  tbl[6];
    logic [NC-1:0][PW-1:0] fr;
    int                    fr_n;
    bit                    fr_wb;
    logic [2:0][PW-1:0]    exp_p;
    logic [2:0][CW-1:0]    exp_c;
    int                    errors = 0;
    int                    checks = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
        end
    endtask

    // Reference: rank by score descending, earliest index first on ties; zero scores never enter.
    task automatic model();
        bit used[NC];
        for (int i = 0; i < NC; i++) used[i] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            int best = -1;
            for (int i = 0; i < fr_n; i++)
                if (!used[i] && (best < 0 || fr[i] > fr[best])) best = i;
            exp_p[k] = '0;
            exp_c[k] = '0;
            if (best >= 0) begin
                used[best] = 1'b1;
                if (fr[best] != 0) begin
                    exp_p[k] = fr[best];
                    exp_c[k] = CW'(best);
                end
            end
        end
    endtask

    task automatic drive_beats(input int cnt);
        for (int i = 0; i < cnt; i++) begin
            @(negedge clk);
            score_valid = 1'b1;
            score       = fr[i];
            score_last  = (i == fr_n - 1);
            word_begin  = fr_wb;
        end
        @(negedge clk);
        score_valid = 1'b0;
        score_last  = 1'b0;
    endtask

    task automatic check_outs(input string tag);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("%s prob[%0d]", tag, k), 64'(prob[k]), 64'(exp_p[k]));
            chk($sformatf("%s char[%0d]", tag, k), 64'(chr[k]), 64'(exp_c[k]));
        end
    endtask

    // Sends the frame, checks the issue cycle, holds `hold` extra wait cycles with a
    // spurious beat on the bus, then steps the decoder.
    task automatic run_frame(input string tag, input int hold);
        drive_beats(fr_n);
        chk({tag, " start"}, 64'(start), 64'(fr_wb));
        chk({tag, " next"}, 64'(nxt), 64'(!fr_wb));
        chk({tag, " busy@issue"}, 64'(busy), 64'd1);
        chk({tag, " ready@issue"}, 64'(score_ready), 64'd0);
        check_outs(tag);
        score_valid = 1'b1;
        score       = 32'hFFFF_FFFF;
        score_last  = 1'b1;
        for (int h = 0; h <= hold; h++) begin
            @(negedge clk);
            chk({tag, " pulse end"}, 64'({start, nxt}), 64'd0);
            chk({tag, " busy@wait"}, 64'(busy), 64'd1);
            chk({tag, " ready@wait"}, 64'(score_ready), 64'd0);
            chk({tag, " timeout@wait"}, 64'(timeout), 64'd0);
            if (h == 0 || h == hold) check_outs({tag, " hold"});
        end
        score_valid = 1'b0;
        score_last  = 1'b0;
        stepped     = 1'b1;
        @(negedge clk);
        stepped = 1'b0;
        chk({tag, " ready after step"}, 64'(score_ready), 64'd1);
        chk({tag, " busy after step"}, 64'(busy), 64'd0);
        check_outs({tag, " kept"});
    endtask

    initial begin
        rst_n = 1'b0; score_valid = 1'b0; score = '0; score_last = 1'b0;
        word_begin = 1'b0; stepped = 1'b0;

        for (int t = 0; t < 6; t++) begin
            tbl[t].sc = '0; tbl[t].ep = '0; tbl[t].ec = '0;
        end
        for (int i = 0; i < NC; i++) tbl[0].sc[i] = PW'(i * 10);
        tbl[0].n = 27; tbl[0].wb = 1'b1;
        tbl[0].ep[0] = 260; tbl[0].ep[1] = 250; tbl[0].ep[2] = 240;
        tbl[0].ec[0] = 26;  tbl[0].ec[1] = 25;  tbl[0].ec[2] = 24;
        for (int i = 0; i < NC; i++) tbl[1].sc[i] = 5;
        tbl[1].sc[3] = 100; tbl[1].sc[7] = 100; tbl[1].sc[1] = 50;
        tbl[1].n = 27; tbl[1].wb = 1'b0;
        tbl[1].ep[0] = 100; tbl[1].ep[1] = 100; tbl[1].ep[2] = 50;
        tbl[1].ec[0] = 3;   tbl[1].ec[1] = 7;   tbl[1].ec[2] = 1;
        tbl[2].sc[0] = 9; tbl[2].sc[1] = 4; tbl[2].n = 2; tbl[2].wb = 1'b1;
        tbl[2].ep[0] = 9; tbl[2].ep[1] = 4; tbl[2].ec[1] = 1;
        for (int i = 0; i < NC; i++) tbl[3].sc[i] = 7;
        tbl[3].n = 27; tbl[3].wb = 1'b0;
        tbl[3].ep[0] = 7; tbl[3].ep[1] = 7; tbl[3].ep[2] = 7;
        tbl[3].ec[0] = 0; tbl[3].ec[1] = 1; tbl[3].ec[2] = 2;
        tbl[4].sc[0] = 32'hFFFF_FFFF; tbl[4].n = 1; tbl[4].wb = 1'b1;
        tbl[4].ep[0] = 32'hFFFF_FFFF;
        tbl[5].sc[0] = 32'h8000_0000; tbl[5].sc[1] = 32'h7FFF_FFFF;
        tbl[5].sc[2] = 32'hFFFF_FFFE; tbl[5].sc[3] = 3; tbl[5].sc[4] = 32'hFFFF_FFFE;
        tbl[5].n = 5; tbl[5].wb = 1'b0;
        tbl[5].ep[0] = 32'hFFFF_FFFE; tbl[5].ep[1] = 32'hFFFF_FFFE; tbl[5].ep[2] = 32'h8000_0000;
        tbl[5].ec[0] = 2; tbl[5].ec[1] = 4; tbl[5].ec[2] = 0;

        #2;
        chk("reset ready", 64'(score_ready), 64'd1);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset pulses", 64'({start, nxt, timeout}), 64'd0);
        chk("reset prob", 64'(prob), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int t = 0; t < 6; t++) begin
            fr = tbl[t].sc; fr_n = tbl[t].n; fr_wb = tbl[t].wb;
            exp_p = tbl[t].ep; exp_c = tbl[t].ec;
            run_frame($sformatf("vec%0d", t), (t == 1) ? 20 : 1);
        end

        for (int r = 0; r < 10; r++) begin
            fr_n  = $urandom_range(1, NC);
            fr_wb = 1'($urandom_range(0, 1));
            for (int i = 0; i < NC; i++)
                fr[i] = (r < 5) ? PW'($urandom_range(0, 12)) : PW'($urandom);
            model();
            run_frame($sformatf("rand%0d", r), $urandom_range(0, 4));
        end

        // Reset during beat 12 of a frame, then a clean frame.
        for (int i = 0; i < NC; i++) fr[i] = PW'($urandom_range(500, 900));
        fr_n = NC; fr_wb = 1'b1;
        drive_beats(12);
        rst_n = 1'b0;
        #1;
        chk("midrst prob", 64'(prob), 64'd0);
        chk("midrst char", 64'(chr), 64'd0);
        chk("midrst ready", 64'(score_ready), 64'd1);
        chk("midrst busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NC; i++) fr[i] = PW'($urandom_range(0, 400));
        fr_wb = 1'b0;
        model();
        run_frame("postrst", 2);

`ifdef TOPK_TIMEOUT_EN
        fr_n = 3; fr_wb = 1'b1;
        model();
        drive_beats(fr_n);
        chk("wd start", 64'(start), 64'd1);
        for (int c = 1; c <= 257; c++) begin
            @(negedge clk);
            if (c <= 255) begin
                chk("wd timeout early", 64'(timeout), 64'd0);
                chk("wd busy", 64'(busy), 64'd1);
            end else if (c == 256) begin
                chk("wd timeout pulse", 64'(timeout), 64'd1);
                chk("wd busy drop", 64'(busy), 64'd0);
                chk("wd ready", 64'(score_ready), 64'd1);
            end else begin
                chk("wd pulse end", 64'(timeout), 64'd0);
            end
        end
`else
        fr_n = 4; fr_wb = 1'b0;
        for (int i = 0; i < NC; i++) fr[i] = PW'($urandom_range(1, 50));
        model();
        run_frame("longwait", 300);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
